// File: rtl/ps2_key_controller.sv
// PS/2 keyboard receiver in the system clock domain: pin sync, 11-bit framing,
// E0/F0 prefix decoding into one-cycle key events, and held flags for four keys.
module ps2_key_controller #(
    parameter int unsigned TIMEOUT_CYC = 200000,
    parameter logic [7:0]  KEY0        = 8'h24,
    parameter logic [7:0]  KEY1        = 8'h2D,
    parameter logic [7:0]  KEY2        = 8'h1C,
    parameter logic [7:0]  KEY3        = 8'h23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_released,
    output logic [3:0] key_down,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [3:0][7:0] KEYS = {KEY3, KEY2, KEY1, KEY0};

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXTBRK} dec_t;

    logic          c_s1_q, c_s2_q, c_prev_q, d_s1_q, d_s2_q;
    logic          fall;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [10:0]   shift_q, shift_d;
    logic          done_q, done_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_hit;
    logic [7:0]    rx_byte;
    logic          good, bad;
    dec_t          state_q, state_d;
    logic          emit, emit_ext, emit_brk;
    logic          key_valid_q, frame_err_q, key_ext_q, key_rel_q;
    logic [7:0]    key_code_q;
    logic [3:0]    key_down_q, key_down_d;

    // Sync flops reset high so reset itself never looks like a ps2_clk fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_s1_q   <= 1'b1;
            c_s2_q   <= 1'b1;
            c_prev_q <= 1'b1;
            d_s1_q   <= 1'b1;
            d_s2_q   <= 1'b1;
        end else begin
            c_s1_q   <= ps2_clk;
            c_s2_q   <= c_s1_q;
            c_prev_q <= c_s2_q;
            d_s1_q   <= ps2_data;
            d_s2_q   <= d_s1_q;
        end
    end

    assign fall = c_prev_q & ~c_s2_q;

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        done_d    = 1'b0;
        tmo_d     = tmo_q;
        tmo_hit   = 1'b0;
        if (fall) begin
            shift_d = {d_s2_q, shift_q[10:1]};
            tmo_d   = '0;
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = 4'd0;
                done_d    = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                bit_cnt_d = 4'd0;
                tmo_d     = '0;
                tmo_hit   = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q <= 4'd0;
            shift_q   <= '0;
            done_q    <= 1'b0;
            tmo_q     <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            done_q    <= done_d;
            tmo_q     <= tmo_d;
        end
    end

    // Frame is judged the cycle after the stop bit lands in the shifter.
    assign rx_byte = shift_q[8:1];
    assign good    = done_q & ~shift_q[0] & shift_q[10] & (^shift_q[9:1]);
    assign bad     = done_q & ~good;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bad || tmo_hit) begin
            state_d = IDLE;
        end else if (good) begin
            unique case (state_q)
                IDLE:    state_d = (rx_byte == 8'hE0) ? EXT :
                                   (rx_byte == 8'hF0) ? BRK : IDLE;
                EXT:     state_d = (rx_byte == 8'hF0) ? EXTBRK :
                                   (rx_byte == 8'hE0) ? EXT : IDLE;
                BRK:     state_d = (rx_byte == 8'hE0) ? EXTBRK :
                                   (rx_byte == 8'hF0) ? BRK : IDLE;
                EXTBRK:  state_d = (rx_byte == 8'hE0 || rx_byte == 8'hF0) ? EXTBRK : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        emit     = good && rx_byte != 8'hE0 && rx_byte != 8'hF0;
        emit_ext = (state_q == EXT) || (state_q == EXTBRK);
        emit_brk = (state_q == BRK) || (state_q == EXTBRK);
    end

    always_comb begin
        key_down_d = key_down_q;
        if (emit && !emit_ext) begin
            for (int n = 0; n < 4; n++) begin
                if (rx_byte == KEYS[n]) key_down_d[n] = ~emit_brk;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            key_code_q  <= 8'h00;
            key_ext_q   <= 1'b0;
            key_rel_q   <= 1'b0;
            key_down_q  <= 4'h0;
        end else begin
            key_valid_q <= emit;
            frame_err_q <= bad;
            key_down_q  <= key_down_d;
            if (emit) begin
                key_code_q <= rx_byte;
                key_ext_q  <= emit_ext;
                key_rel_q  <= emit_brk;
            end
        end
    end

    assign key_valid    = key_valid_q;
    assign frame_err    = frame_err_q;
    assign key_code     = key_code_q;
    assign key_ext      = key_ext_q;
    assign key_released = key_rel_q;
    assign key_down     = key_down_q;
endmodule

// File: tb/tb_ps2_key_controller.sv
// Self-checking bench: directed PS/2 scenarios plus random byte streams against a
// prefix-flag reference model of the keyboard protocol.
module tb_ps2_key_controller;
    localparam int HALF = 6;
    localparam int TMO  = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       key_valid, key_ext, key_released, frame_err;
    logic [7:0] key_code;
    logic [3:0] key_down;

    ps2_key_controller #(.TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext),
        .key_released(key_released), .key_down(key_down), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int vcnt = 0, ecnt = 0, v_cyc = 0, t_stop = 0;
    logic [7:0] v_code;
    logic       v_ext, v_rel;

    // reference model state
    bit         m_ext, m_brk;
    logic [3:0] m_down;
    logic [7:0] keys [4] = '{8'h24, 8'h2D, 8'h1C, 8'h23};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (key_valid) begin
                vcnt   <= vcnt + 1;
                v_code <= key_code;
                v_ext  <= key_ext;
                v_rel  <= key_released;
                v_cyc  <= cyc;
            end
            if (frame_err) ecnt <= ecnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input bit badpar, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ badpar, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            repeat (HALF) @(posedge clk);
            #1 ps2_clk = 1'b0;
            if (i == 10) t_stop = cyc;
            repeat (HALF) @(posedge clk);
            #1 ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic do_frame(input logic [7:0] b, input bit badpar);
        int  v0, e0;
        bit  exp_emit, exp_ext, exp_rel;
        v0 = vcnt;
        e0 = ecnt;
        exp_emit = 1'b0;
        exp_ext  = 1'b0;
        exp_rel  = 1'b0;
        if (badpar) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            exp_emit = 1'b1;
            exp_ext  = m_ext;
            exp_rel  = m_brk;
            if (!m_ext)
                for (int n = 0; n < 4; n++)
                    if (keys[n] == b) m_down[n] = ~m_brk;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
        send_bits(b, badpar, 11);
        repeat (12) @(posedge clk);
        #1;
        chk("vld_cnt", vcnt - v0, exp_emit);
        if (exp_emit) begin
            chk("code", v_code, b);
            chk("ext", v_ext, exp_ext);
            chk("rel", v_rel, exp_rel);
            chk("latency", v_cyc - t_stop, 4);
        end
        chk("key_down", key_down, m_down);
        chk("ferr_cnt", ecnt - e0, badpar);
    endtask

    initial begin
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        m_down = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {key_valid, key_code, key_ext, key_released, key_down, frame_err}, 0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        do_frame(8'h24, 0);
        do_frame(8'hF0, 0);
        do_frame(8'h24, 0);
        do_frame(8'hE0, 0);
        do_frame(8'hF0, 0);
        do_frame(8'h75, 0);
        do_frame(8'h2D, 1);
        do_frame(8'h2D, 0);

        // partial frame abandoned by timeout, then a clean frame
        send_bits(8'h55, 0, 5);
        m_ext = 1'b0;
        m_brk = 1'b0;
        repeat (TMO + 50) @(posedge clk);
        #1;
        do_frame(8'h1C, 0);

        // reset in the middle of a break prefix
        send_bits(8'hF0, 0, 6);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_outs", {key_valid, key_code, key_ext, key_released, key_down, frame_err}, 0);
        rst = 1'b0;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        m_down = 4'h0;
        repeat (4) @(posedge clk);
        #1;
        do_frame(8'h23, 0);

        for (int k = 0; k < 60; k++) begin
            logic [7:0] b;
            int r;
            r = $urandom_range(0, 9);
            if (r < 2)      b = 8'hE0;
            else if (r < 4) b = 8'hF0;
            else if (r < 7) b = keys[$urandom_range(0, 3)];
            else            b = 8'($urandom);
            do_frame(b, $urandom_range(0, 9) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
